// File: rtl/axi_wr_buffer.sv
// axi_wr_buffer: LSU store queue that drains one AXI4-Lite write (AW+W+B) at a time.
// Define AXI_WR_BUF_ERR_CAPTURE_EN to report non-OKAY responses on o_err / o_err_addr.
module axi_wr_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_data,
    input  logic [3:0]  i_req_wstrb,
    output logic [31:0] o_axi_awaddr,
    output logic        o_axi_awvalid,
    input  logic        i_axi_awready,
    output logic [31:0] o_axi_wdata,
    output logic [3:0]  o_axi_wstrb,
    output logic        o_axi_wvalid,
    input  logic        i_axi_wready,
    input  logic [1:0]  i_axi_bresp,
    input  logic        i_axi_bvalid,
    output logic        o_axi_bready,
    output logic        o_busy,
    output logic        o_err,
    output logic [31:0] o_err_addr
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [31:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [3:0]       strb_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [1:0]       state;
    logic             aw_done;
    logic             w_done;
    logic             push;
    logic             pop;
    logic             aw_hs;
    logic             w_hs;

    assign o_req_ready   = count < FULL_COUNT;
    assign push          = i_req_valid && o_req_ready;
    assign pop           = i_axi_bvalid && o_axi_bready;
    assign o_axi_awvalid = (state == ST_ADDR) && !aw_done;
    assign o_axi_wvalid  = (state == ST_ADDR) && !w_done;
    assign o_axi_bready  = (state == ST_RESP);
    assign aw_hs         = o_axi_awvalid && i_axi_awready;
    assign w_hs          = o_axi_wvalid && i_axi_wready;
    assign o_axi_awaddr  = addr_mem[head];
    assign o_axi_wdata   = data_mem[head];
    assign o_axi_wstrb   = strb_mem[head];
    assign o_busy        = (count != '0) || (state != ST_IDLE);

    always_ff @(posedge i_clock) begin
        if (push) begin
            addr_mem[tail] <= i_req_addr;
            data_mem[tail] <= i_req_data;
            strb_mem[tail] <= i_req_wstrb;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Leave ADDR on the cycle the last outstanding handshake lands, not a cycle after its flag.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (count != '0) state <= ST_ADDR;
                ST_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= ST_RESP;
                end
                ST_RESP: begin
                    if (pop) begin
                        state   <= ST_IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXI_WR_BUF_ERR_CAPTURE_EN
    logic [31:0] err_addr_q;

    assign o_err      = pop && (i_axi_bresp != 2'b00);
    assign o_err_addr = err_addr_q;

    always_ff @(posedge i_clock) begin
        if (i_reset)    err_addr_q <= '0;
        else if (o_err) err_addr_q <= o_axi_awaddr;
    end
`else
    logic unused_bresp;

    assign unused_bresp = ^i_axi_bresp;
    assign o_err        = 1'b0;
    assign o_err_addr   = '0;
`endif

endmodule
